// File: rtl/regfile_sb.sv
// Parametrised integer register file (x0 hard-wired to zero) with two combinational
// read ports, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     readreg1,
  input  logic [AW-1:0]     readreg2,
  output logic [XLEN-1:0]   readData1,
  output logic [XLEN-1:0]   readData2,
  output logic              ready1,
  output logic              ready2,
  input  logic              regwrite,
  input  logic [AW-1:0]     writereg,
  input  logic [XLEN-1:0]   write_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic [NREGS-1:0]  busy,
  output logic              wb_unexpected
);

  localparam logic [AW-1:0]   ZERO_ADDR = {AW{1'b0}};
  localparam logic [XLEN-1:0] ZERO_DATA = {XLEN{1'b0}};
  localparam logic            BYP_EN    = (BYPASS != 0);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic             wb_unexpected_r;
  logic             wb_unexpected_nxt_s;
  logic             wr_en_s;
  logic             issue_en_s;
  logic             bypass1_s;
  logic             bypass2_s;

  // Qualify write and issue: anything aimed at x0 is dropped here.
  always_comb begin
    wr_en_s    = regwrite && (writereg != ZERO_ADDR);
    issue_en_s = issue_valid && (issue_rd != ZERO_ADDR);
  end

  // Scoreboard next state: a new producer (set) outranks a retiring one (clear).
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_en_s && (issue_rd == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_en_s && (writereg == AW'(r))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Debug flag: a writeback that finds no pending allocation.
  always_comb begin
    if (wr_en_s) begin
      wb_unexpected_nxt_s = !busy_r[writereg];
    end else begin
      wb_unexpected_nxt_s = 1'b0;
    end
  end

  // Data array update; x0 storage is never written and stays at its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= ZERO_DATA;
      end
    end else if (wr_en_s) begin
      regs_r[writereg] <= write_data;
    end else begin
      regs_r[writereg] <= regs_r[writereg];
    end
  end

  // Scoreboard and debug flag registers; reset discards pending allocations.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r          <= {NREGS{1'b0}};
      wb_unexpected_r <= 1'b0;
    end else begin
      busy_r          <= busy_nxt_s;
      wb_unexpected_r <= wb_unexpected_nxt_s;
    end
  end

  // Forwarding hit detection; wr_en_s already excludes x0.
  always_comb begin
    bypass1_s = BYP_EN && wr_en_s && (writereg == readreg1);
    bypass2_s = BYP_EN && wr_en_s && (writereg == readreg2);
  end

  // Read port 1 data and operand readiness.
  always_comb begin
    if (readreg1 == ZERO_ADDR) begin
      readData1 = ZERO_DATA;
    end else if (bypass1_s) begin
      readData1 = write_data;
    end else begin
      readData1 = regs_r[readreg1];
    end
    ready1 = (readreg1 == ZERO_ADDR) || !busy_r[readreg1] || bypass1_s;
  end

  // Read port 2 data and operand readiness.
  always_comb begin
    if (readreg2 == ZERO_ADDR) begin
      readData2 = ZERO_DATA;
    end else if (bypass2_s) begin
      readData2 = write_data;
    end else begin
      readData2 = regs_r[readreg2];
    end
    ready2 = (readreg2 == ZERO_ADDR) || !busy_r[readreg2] || bypass2_s;
  end

  assign busy          = busy_r;
  assign wb_unexpected = wb_unexpected_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing 32x32 instance and a non-bypassing 64x16 one.
module tb_regfile_sb;

  localparam int A_RD1 = 0, A_RD2 = 1, A_RDY1 = 2, A_RDY2 = 3, A_BUSY = 4, A_WBU = 5;
  localparam int B_RD1 = 6, B_RDY1 = 7, B_BUSY = 8, B_WBU = 9;

  logic clk = 1'b0;
  logic rst;

  logic [4:0]  a_rr1, a_rr2, a_wr, a_ird;
  logic [31:0] a_rd1, a_rd2, a_wd;
  logic        a_rdy1, a_rdy2, a_we, a_iv, a_wbu;
  logic [31:0] a_busy;

  logic [3:0]  b_rr1, b_rr2, b_wr, b_ird;
  logic [63:0] b_rd1, b_rd2, b_wd;
  logic        b_rdy1, b_rdy2, b_we, b_iv, b_wbu;
  logic [15:0] b_busy;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .readreg1(a_rr1), .readreg2(a_rr2), .readData1(a_rd1), .readData2(a_rd2),
    .ready1(a_rdy1), .ready2(a_rdy2),
    .regwrite(a_we), .writereg(a_wr), .write_data(a_wd),
    .issue_valid(a_iv), .issue_rd(a_ird), .busy(a_busy), .wb_unexpected(a_wbu)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .readreg1(b_rr1), .readreg2(b_rr2), .readData1(b_rd1), .readData2(b_rd2),
    .ready1(b_rdy1), .ready2(b_rdy2),
    .regwrite(b_we), .writereg(b_wr), .write_data(b_wd),
    .issue_valid(b_iv), .issue_rd(b_ird), .busy(b_busy), .wb_unexpected(b_wbu)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_of(input int sel);
    case (sel)
      A_RD1:   return {32'h0, a_rd1};
      A_RD2:   return {32'h0, a_rd2};
      A_RDY1:  return {63'h0, a_rdy1};
      A_RDY2:  return {63'h0, a_rdy2};
      A_BUSY:  return {32'h0, a_busy};
      A_WBU:   return {63'h0, a_wbu};
      B_RD1:   return b_rd1;
      B_RDY1:  return {63'h0, b_rdy1};
      B_BUSY:  return {48'h0, b_busy};
      B_WBU:   return {63'h0, b_wbu};
      default: return 64'hx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask

  // Let combinational outputs settle, then pop and compare every pending expectation.
  task automatic drain();
    exp_t e;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_val(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we = 1'b0; a_wr = 5'd0; a_wd = 32'h0; a_iv = 1'b0; a_ird = 5'd0;
    a_rr1 = 5'd0; a_rr2 = 5'd0;
    b_we = 1'b0; b_wr = 4'd0; b_wd = 64'h0; b_iv = 1'b0; b_ird = 4'd0;
    b_rr1 = 4'd0; b_rr2 = 4'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state: every address reads zero and ready.
    expect_val("a_busy_rst", A_BUSY, 64'h0);
    expect_val("a_wbu_rst", A_WBU, 64'h0);
    expect_val("b_busy_rst", B_BUSY, 64'h0);
    expect_val("b_wbu_rst", B_WBU, 64'h0);
    drain();
    for (int a = 0; a < 32; a++) begin
      a_rr1 = 5'(a);
      a_rr2 = 5'(31 - a);
      b_rr1 = 4'(a % 16);
      expect_val("a_rd1_rst", A_RD1, 64'h0);
      expect_val("a_rd2_rst", A_RD2, 64'h0);
      expect_val("a_rdy1_rst", A_RDY1, 64'h1);
      expect_val("a_rdy2_rst", A_RDY2, 64'h1);
      expect_val("b_rd1_rst", B_RD1, 64'h0);
      expect_val("b_rdy1_rst", B_RDY1, 64'h1);
      drain();
    end

    // Issue 5, then writeback with bypass.
    idle();
    a_iv = 1'b1; a_ird = 5'd5;
    tick();
    idle();
    a_rr1 = 5'd5;
    expect_val("a_busy5", A_BUSY, 64'h20);
    expect_val("a_rdy1_busy5", A_RDY1, 64'h0);
    drain();
    a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hDEADBEEF; a_rr1 = 5'd5; a_rr2 = 5'd5;
    expect_val("a_rd1_byp5", A_RD1, 64'hDEADBEEF);
    expect_val("a_rd2_byp5", A_RD2, 64'hDEADBEEF);
    expect_val("a_rdy1_byp5", A_RDY1, 64'h1);
    expect_val("a_rdy2_byp5", A_RDY2, 64'h1);
    drain();
    tick();
    idle();
    a_rr1 = 5'd5;
    expect_val("a_busy_clr5", A_BUSY, 64'h0);
    expect_val("a_rd1_stored5", A_RD1, 64'hDEADBEEF);
    expect_val("a_rdy1_stored5", A_RDY1, 64'h1);
    expect_val("a_wbu_expected5", A_WBU, 64'h0);
    drain();

    // WAW on 7: simultaneous issue and writeback keeps 7 busy.
    a_iv = 1'b1; a_ird = 5'd7;
    tick();
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h12345678;
    tick();
    idle();
    a_rr1 = 5'd7;
    expect_val("a_busy7_waw", A_BUSY, 64'h80);
    expect_val("a_rdy1_waw7", A_RDY1, 64'h0);
    expect_val("a_rd1_waw7", A_RD1, 64'h12345678);
    expect_val("a_wbu_waw7", A_WBU, 64'h0);
    drain();
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h12345678;
    tick();
    idle();
    expect_val("a_busy7_clr", A_BUSY, 64'h0);
    drain();

    // x0: write and issue are both ignored.
    a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hFFFFFFFF; a_iv = 1'b1; a_ird = 5'd0;
    a_rr1 = 5'd0; a_rr2 = 5'd0;
    expect_val("a_rd1_x0_same", A_RD1, 64'h0);
    expect_val("a_rdy1_x0_same", A_RDY1, 64'h1);
    drain();
    tick();
    idle();
    expect_val("a_rd1_x0", A_RD1, 64'h0);
    expect_val("a_rd2_x0", A_RD2, 64'h0);
    expect_val("a_rdy2_x0", A_RDY2, 64'h1);
    expect_val("a_busy_x0", A_BUSY, 64'h0);
    expect_val("a_wbu_x0", A_WBU, 64'h0);
    drain();

    // Non-bypass instance: writeback to non-busy 9 pulses wb_unexpected once.
    b_we = 1'b1; b_wr = 4'd9; b_wd = 64'h99;
    tick();
    idle();
    b_rr1 = 4'd9;
    expect_val("b_wbu_set", B_WBU, 64'h1);
    expect_val("b_rd1_r9", B_RD1, 64'h99);
    drain();
    tick();
    expect_val("b_wbu_clear", B_WBU, 64'h0);
    drain();

    // Non-bypass: no forwarding, ready only the cycle after writeback.
    b_iv = 1'b1; b_ird = 4'd3;
    tick();
    idle();
    b_rr1 = 4'd3;
    expect_val("b_busy3", B_BUSY, 64'h8);
    expect_val("b_rdy1_busy3", B_RDY1, 64'h0);
    drain();
    b_we = 1'b1; b_wr = 4'd3; b_wd = 64'hA5A5A5A5A5A5A5A5; b_rr1 = 4'd3;
    expect_val("b_rd1_old3", B_RD1, 64'h0);
    expect_val("b_rdy1_wb3", B_RDY1, 64'h0);
    drain();
    tick();
    idle();
    b_rr1 = 4'd3;
    expect_val("b_rd1_new3", B_RD1, 64'hA5A5A5A5A5A5A5A5);
    expect_val("b_rdy1_new3", B_RDY1, 64'h1);
    expect_val("b_busy_clr3", B_BUSY, 64'h0);
    expect_val("b_wbu_wb3", B_WBU, 64'h0);
    drain();

    // Reset mid-operation beats a concurrent writeback and drops pending issues.
    a_iv = 1'b1; a_ird = 5'd2;
    tick();
    a_ird = 5'd4;
    tick();
    a_ird = 5'd6;
    tick();
    idle();
    expect_val("a_busy_246", A_BUSY, 64'h54);
    drain();
    rst = 1'b1;
    a_we = 1'b1; a_wr = 5'd4; a_wd = 32'h55AA55AA;
    tick();
    rst = 1'b0;
    idle();
    a_rr1 = 5'd4; a_rr2 = 5'd5;
    b_rr1 = 4'd3;
    expect_val("a_busy_postrst", A_BUSY, 64'h0);
    expect_val("a_wbu_postrst", A_WBU, 64'h0);
    expect_val("a_rd1_r4_postrst", A_RD1, 64'h0);
    expect_val("a_rd2_r5_postrst", A_RD2, 64'h0);
    expect_val("a_rdy1_postrst", A_RDY1, 64'h1);
    expect_val("b_rd1_r3_postrst", B_RD1, 64'h0);
    drain();
    a_rr1 = 5'd7;
    expect_val("a_rd1_r7_postrst", A_RD1, 64'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the integer register file.
- Configurable data width and register count, with register 0 hard-wired to zero.
- Two combinational read ports with optional write-to-read bypass.
- Per-register busy scoreboard: the pipeline's issue stage marks a destination pending, writeback clears it, and each read port reports operand readiness to hazard/stall logic.

Parameters:
- XLEN, 32: data width of every register and data port.
- NREGS, 32: number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS): register address width (derived; not overridden).
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports; 0 = reads show only stored contents.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- readreg1  in  AW  read port 1 address.
- readreg2  in  AW  read port 2 address.
- readData1  out  XLEN  read port 1 data.
- readData2  out  XLEN  read port 2 data.
- ready1  out  1  readreg1 operand is valid (not pending, or bypassed).
- ready2  out  1  readreg2 operand is valid.
- regwrite  in  1  writeback enable.
- writereg  in  AW  writeback destination.
- write_data  in  XLEN  writeback data.
- issue_valid  in  1  issue stage allocates a destination this cycle.
- issue_rd  in  AW  destination being allocated.
- busy  out  NREGS  scoreboard vector, bit i = register i pending.
- wb_unexpected  out  1  registered flag: last-cycle writeback hit a non-busy register.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst is synchronous and active-high.
- Reset state: on the rst edge, all registers = 0, busy = 0, wb_unexpected = 0. rst has priority over regwrite and issue_valid in the same cycle. Reset is valid mid-operation, and any pending allocations are discarded.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are ignored, issue_rd = 0 is ignored, and ready is always 1 when addressing it.
- Write:
  - On the rising clk edge, if regwrite and writereg != 0, reg[writereg] <= write_data.
  - Stored data is visible through the array one cycle later.
- Read:
  - Purely combinational, zero latency.
  - readDataN = bypass value if (BYPASS = 1, regwrite, writereg == readregN, readregN != 0); otherwise reg[readregN].
  - Both ports may address the same register, and both get identical results.
- Scoreboard update per cycle, evaluated per register r != 0:
  - set = issue_valid && issue_rd == r.
  - clr = regwrite && writereg == r.
  - busy[r] next = set ? 1 : (clr ? 0 : busy[r]). Set wins on a simultaneous set/clear of the same register, because the new producer is younger than the retiring one.
  - Issuing a register that is already busy keeps it busy. This is a legal WAW; the register stays busy until a later writeback with no concurrent issue.
- Ready:
  - readyN = (readregN == 0) || !busy[readregN] || (BYPASS && regwrite && writereg == readregN).
  - With BYPASS = 0, a busy register stays not-ready until the cycle after its writeback.
  - ready does not account for a same-cycle issue_valid; busy reflects registered state only.
- wb_unexpected:
  - Registered. Next value = regwrite && writereg != 0 && !busy[writereg].
  - Debug only: the write still occurs. Held for one cycle, then re-evaluated.
- No internal state machine beyond NREGS busy flops and the data array. Both register updates and scoreboard updates are single-cycle.

Test Plan:
- Reset, then read every address → all readData = 0, ready = 1, busy = 0, wb_unexpected = 0.
- Issue rd = 5, next cycle read 5 → busy[5] = 1, ready1 = 0. Then regwrite 5 with 0xDEADBEEF (BYPASS = 1) → same cycle readData1 = 0xDEADBEEF, ready1 = 1. Next cycle busy[5] = 0 and the stored value reads back.
- Same-cycle issue rd = 7 and writeback to 7 with 0x12345678, after a prior issue of 7 → reg[7] = 0x12345678, busy[7] remains 1, ready = 0 on the following cycle.
- Write 0xFFFFFFFF to 0 and issue rd = 0 → readData = 0, busy[0] = 0, ready = 1, wb_unexpected = 0.
- BYPASS = 0 build (XLEN = 64, NREGS = 16): issue 3, then writeback 3 with 0xA5A5A5A5A5A5A5A5 → same cycle readData shows the old value and ready = 0. Next cycle shows the new value with ready = 1. Also: writeback to non-busy 9 → wb_unexpected = 1 for exactly one cycle.
- Issue 2, 4, 6 then assert rst with regwrite to 4 in the same cycle → all registers 0, busy = 0, reg[4] not written.
